// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing a single WIDTH-bit incrementer across NUM_CH event counters.
// Optional build macro COUNTER_RR_SCHEDULER_SAT_EN makes counts saturate instead of wrapping.

module counter_rr_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc_req,
    input  logic             i_grant,
    input  logic             i_at_max,
    input  logic [WIDTH-1:0] i_next_q,
    output logic [WIDTH-1:0] o_q,
    output logic             o_pend,
    output logic             o_wrap,
    output logic             o_drop
);
    logic [WIDTH-1:0] r_q;
    logic             r_pend;
    logic             r_wrap;
    logic             r_drop;

    // Clear outranks both a fresh request and a grant landing this cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q    <= '0;
            r_pend <= 1'b0;
            r_wrap <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (i_grant)
                r_q <= i_next_q;
            r_pend <= i_inc_req | (r_pend & ~i_grant);
            if (i_inc_req && r_pend && !i_grant)
                r_drop <= 1'b1;
            r_wrap <= i_grant & i_at_max;
        end
    end

    assign o_q    = r_q;
    assign o_pend = r_pend;
    assign o_wrap = r_wrap;
    assign o_drop = r_drop;
endmodule

module counter_rr_scheduler #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       inc_req,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       pend,
    output logic [NUM_CH-1:0]       grant,
    output logic [NUM_CH-1:0]       wrap,
    output logic [NUM_CH-1:0]       drop,
    output logic                    busy
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][WIDTH-1:0] w_q;
    logic [NUM_CH-1:0]            w_pend;
    logic [NUM_CH-1:0]            w_grant;
    logic [IDX_W-1:0]             w_grant_idx;
    logic                         w_any;
    logic [WIDTH-1:0]             w_sel_q;
    logic                         w_at_max;
    logic [WIDTH-1:0]             w_next_q;
    logic [IDX_W-1:0]             r_last;

    // Search starts just after the last served channel and wraps once around.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_any       = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_any && w_pend[(int'(r_last) + k) % NUM_CH]) begin
                w_any                                  = 1'b1;
                w_grant[(int'(r_last) + k) % NUM_CH]   = 1'b1;
                w_grant_idx                            = IDX_W'((int'(r_last) + k) % NUM_CH);
            end
        end
    end

    // The one shared incrementer: operand is muxed from the granted channel.
    assign w_sel_q  = w_q[w_grant_idx];
    assign w_at_max = &w_sel_q;
`ifdef COUNTER_RR_SCHEDULER_SAT_EN
    assign w_next_q = w_at_max ? w_sel_q : w_sel_q + WIDTH'(1);
`else
    assign w_next_q = w_sel_q + WIDTH'(1);
`endif

    // last advances even when the granted channel is cleared in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= IDX_W'(NUM_CH - 1);
        else if (w_any)
            r_last <= w_grant_idx;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            counter_rr_channel #(.WIDTH(WIDTH)) u_ch (
                .clk       (clk),
                .rst       (rst),
                .i_clr     (clr[gi]),
                .i_inc_req (inc_req[gi]),
                .i_grant   (w_grant[gi]),
                .i_at_max  (w_at_max),
                .i_next_q  (w_next_q),
                .o_q       (w_q[gi]),
                .o_pend    (w_pend[gi]),
                .o_wrap    (wrap[gi]),
                .o_drop    (drop[gi])
            );
            assign q[gi*WIDTH +: WIDTH] = w_q[gi];
        end
    endgenerate

    assign pend  = w_pend;
    assign grant = w_grant;
    assign busy  = |w_pend;
endmodule
